// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble injection, hold and flush.
// One-cycle register latency; PCWrite_o/IF_ID_Write_o are combinational freeze controls.
module id_ex_hazard_stage #(
   parameter int DATA_W          = 32,
   parameter int LOAD_USE_CYCLES = 1,
   parameter int CNT_W           = 16
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              hold_i,
   input  logic              flush_i,
   input  logic              IF_ID_valid_i,
   input  logic [4:0]        IF_ID_RS_i,
   input  logic [4:0]        IF_ID_RT_i,
   input  logic [4:0]        IF_ID_RD_i,
   input  logic [8:0]        ID_ctrl_i,
   input  logic [DATA_W-1:0] ID_RSdata_i,
   input  logic [DATA_W-1:0] ID_RTdata_i,
   input  logic [DATA_W-1:0] ID_Imm_i,
   output logic              PCWrite_o,
   output logic              IF_ID_Write_o,
   output logic              ID_EX_valid_o,
   output logic [4:0]        ID_EX_RS_o,
   output logic [4:0]        ID_EX_RT_o,
   output logic [4:0]        ID_EX_RD_o,
   output logic [8:0]        ID_EX_ctrl_o,
   output logic [DATA_W-1:0] ID_EX_RSdata_o,
   output logic [DATA_W-1:0] ID_EX_RTdata_o,
   output logic [DATA_W-1:0] ID_EX_Imm_o,
   output logic [CNT_W-1:0]  stall_count_o
);

   localparam int MEM_READ_BIT = 7;

   typedef enum logic {RUN, STALL} state_t;

   typedef struct packed {
      logic              valid;
      logic [4:0]        rs;
      logic [4:0]        rt;
      logic [4:0]        rd;
      logic [8:0]        ctrl;
      logic [DATA_W-1:0] rs_data;
      logic [DATA_W-1:0] rt_data;
      logic [DATA_W-1:0] imm;
   } id_ex_t;

   id_ex_t           id_ex_q;
   id_ex_t           id_in;
   state_t           state, state_nxt;
   logic [2:0]       remaining, remaining_nxt;
   logic [CNT_W-1:0] stall_count;
   logic             haz;
   logic             load;
   logic             bubble;
   logic             cnt_inc;
   logic             freeze;

   assign id_in = '{valid:   IF_ID_valid_i,
                    rs:      IF_ID_RS_i,
                    rt:      IF_ID_RT_i,
                    rd:      IF_ID_RD_i,
                    ctrl:    ID_ctrl_i,
                    rs_data: ID_RSdata_i,
                    rt_data: ID_RTdata_i,
                    imm:     ID_Imm_i};

   // A load writing $0 never creates a real dependency.
   assign haz = id_ex_q.valid & id_ex_q.ctrl[MEM_READ_BIT] & IF_ID_valid_i
              & (id_ex_q.rt != 5'd0)
              & ((id_ex_q.rt == IF_ID_RS_i) | (id_ex_q.rt == IF_ID_RT_i));

   always_comb begin
      state_nxt     = state;
      remaining_nxt = remaining;
      load          = 1'b0;
      bubble        = 1'b0;
      cnt_inc       = 1'b0;
      freeze        = 1'b0;
      if (hold_i) begin
         freeze = 1'b1;
      end else if (flush_i) begin
         bubble        = 1'b1;
         state_nxt     = RUN;
         remaining_nxt = 3'd0;
      end else if (state == RUN && haz) begin
         bubble  = 1'b1;
         freeze  = 1'b1;
         cnt_inc = 1'b1;
         if (LOAD_USE_CYCLES > 1) begin
            state_nxt     = STALL;
            remaining_nxt = 3'(LOAD_USE_CYCLES - 1);
         end
      end else if (state == STALL) begin
         bubble        = 1'b1;
         freeze        = 1'b1;
         cnt_inc       = 1'b1;
         remaining_nxt = remaining - 3'd1;
         if (remaining == 3'd1) begin
            state_nxt = RUN;
         end
      end else begin
         load = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         id_ex_q     <= '0;
         state       <= RUN;
         remaining   <= 3'd0;
         stall_count <= '0;
      end else begin
         state     <= state_nxt;
         remaining <= remaining_nxt;
         if (bubble) begin
            id_ex_q <= '0;
         end else if (load) begin
            id_ex_q <= id_in;
         end
         if (cnt_inc && stall_count != {CNT_W{1'b1}}) begin
            stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   assign PCWrite_o      = ~freeze;
   assign IF_ID_Write_o  = ~freeze;
   assign ID_EX_valid_o  = id_ex_q.valid;
   assign ID_EX_RS_o     = id_ex_q.rs;
   assign ID_EX_RT_o     = id_ex_q.rt;
   assign ID_EX_RD_o     = id_ex_q.rd;
   assign ID_EX_ctrl_o   = id_ex_q.ctrl;
   assign ID_EX_RSdata_o = id_ex_q.rs_data;
   assign ID_EX_RTdata_o = id_ex_q.rt_data;
   assign ID_EX_Imm_o    = id_ex_q.imm;
   assign stall_count_o  = stall_count;

endmodule
